food_spawner: RTL and testbench
===============================

FOOD_SPAWNER -- requirements
Module: food_spawner

Interface
REQ-001 Parameters SHALL be GRID_W=80 (playfield columns), GRID_H=60 (playfield rows) and MAX_TRIES=16 (sample attempts per spawn, 1..255).
REQ-002 Port clk SHALL be an input, 1 bit: the single system clock; all logic SHALL be on its rising edge.
REQ-003 Port rst SHALL be an input, 1 bit: synchronous, active-low reset.
REQ-004 Port spawn_req SHALL be an input, 1 bit: a one-cycle pulse requesting a new food position (game start or food eaten).
REQ-005 Ports rand_x and rand_y SHALL be inputs, 7 bits each: free-running pseudo-random coordinates from the Random block, new value every cycle.
REQ-006 Ports qry_valid (output, 1), qry_x (output, 7) and qry_y (output, 7) SHALL form the occupancy query to the snake-body checker.
REQ-007 Ports occ_valid (input, 1) and occ_hit (input, 1) SHALL form the checker response; occ_hit=1 means the cell is occupied.
REQ-008 Ports food_x (output, 7), food_y (output, 7) and food_valid (output, 1) SHALL carry the current food position.
REQ-009 Ports busy (output, 1), spawn_done (output, 1, pulse) and spawn_fail (output, 1, pulse) SHALL report status.

Function
REQ-010 The FSM SHALL have states IDLE, SAMPLE, QUERY, WAIT and PLACE; busy=1 in every state except IDLE.
REQ-011 IDLE with spawn_req=1 -> SAMPLE next cycle; food_valid SHALL clear in that same edge and try_cnt SHALL load 0.
REQ-012 SAMPLE SHALL register rand_x/rand_y into cand_x/cand_y and increment try_cnt.
REQ-013 A sample with rand_x>=GRID_W or rand_y>=GRID_H SHALL be rejected (no modulo); the FSM SHALL stay in SAMPLE and resample next cycle.
REQ-014 An in-range sample SHALL move the FSM to QUERY; QUERY SHALL drive qry_valid=1 for exactly one cycle with qry_x/qry_y=cand, then go to WAIT.
REQ-015 WAIT SHALL hold until occ_valid=1: occ_hit=0 -> PLACE; occ_hit=1 -> SAMPLE.
REQ-016 occ_valid SHALL be ignored outside WAIT.
REQ-017 PLACE SHALL load food_x/food_y from cand, set food_valid=1, pulse spawn_done for one cycle, and return to IDLE.
REQ-018 When try_cnt reaches MAX_TRIES and the current sample is rejected or hit, the exhaustion behaviour of REQ-025/026 SHALL apply.
REQ-019 spawn_req while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-020 qry_x/qry_y SHALL hold their last value when qry_valid=0.
REQ-021 Minimum latency SHALL be 5 cycles from spawn_req to spawn_done for a first in-range sample with occ_valid returned in the cycle after qry_valid.

Reset
REQ-022 rst=0 at a clock edge SHALL force IDLE, try_cnt=0, food_x=0, food_y=0, food_valid=0, qry_valid=0, qry_x=0, qry_y=0, busy=0, spawn_done=0 and spawn_fail=0.
REQ-023 Reset mid-spawn SHALL abort the search; no spawn_done or spawn_fail SHALL follow it, and a late occ_valid SHALL be ignored.

Configuration
REQ-024 Macro FOOD_FALLBACK_SCAN_EN SHALL select the behaviour on try exhaustion.
REQ-025 With FOOD_FALLBACK_SCAN_EN defined, exhaustion SHALL enter state SCAN, which queries cells in raster order (x fastest, from (0,0)) using the QUERY/WAIT handshake.
REQ-026 In SCAN, the first free cell SHALL go to PLACE; if every cell is occupied, spawn_fail SHALL pulse and the FSM SHALL return to IDLE with food_valid=0.
REQ-027 Without FOOD_FALLBACK_SCAN_EN, state SCAN SHALL NOT exist; exhaustion SHALL pulse spawn_fail for one cycle and return to IDLE with food_valid=0.

Verification
REQ-028 Reset held 3 cycles, then released -> all outputs 0, busy=0; spawn_req then occ_valid=1, occ_hit=0 -> spawn_done exactly 5 cycles after spawn_req.
REQ-029 rand_x=100, rand_y=10 for 2 cycles, then (12,34) -> no qry_valid for the rejected samples; qry (12,34); free -> food=(12,34), food_valid=1.
REQ-030 First query (5,5) answered occ_hit=1, second (7,9) answered occ_hit=0 -> two qry_valid pulses, food=(7,9), try_cnt=2 at PLACE.
REQ-031 All queries answered occ_hit=1, macro undefined -> spawn_fail after 16 tries, food_valid=0, busy=0; macro defined -> SCAN starts at (0,0), and occ_hit=0 at (3,0) -> food=(3,0).
REQ-032 spawn_req pulsed during WAIT, and rst=0 asserted during WAIT -> extra request ignored; after reset no spawn_done even when occ_valid=1 arrives 1 cycle later.

Source files
------------

// File: rtl/food_spawner.sv
// Food spawner: rejection-samples random grid cells, checks occupancy with the
// snake-body checker and places food. FOOD_FALLBACK_SCAN_EN adds a raster-scan fallback.
module food_spawner #(
    parameter int GRID_W    = 80,
    parameter int GRID_H    = 60,
    parameter int MAX_TRIES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spawn_req,
    input  logic [6:0] rand_x,
    input  logic [6:0] rand_y,
    output logic       qry_valid,
    output logic [6:0] qry_x,
    output logic [6:0] qry_y,
    input  logic       occ_valid,
    input  logic       occ_hit,
    output logic [6:0] food_x,
    output logic [6:0] food_y,
    output logic       food_valid,
    output logic       busy,
    output logic       spawn_done,
    output logic       spawn_fail
);
    // state   | meaning
    // IDLE    | waiting for spawn_req
    // SAMPLE  | capture random candidate, reject out-of-range
    // QUERY   | one-cycle occupancy query for the candidate
    // WAIT    | waiting for the checker response
    // PLACE   | commit candidate as food
    // SCAN    | raster fallback after exhaustion (FOOD_FALLBACK_SCAN_EN only)
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SAMPLE = 3'd1,
        S_QUERY  = 3'd2,
        S_WAIT   = 3'd3,
        S_PLACE  = 3'd4
`ifdef FOOD_FALLBACK_SCAN_EN
        , S_SCAN = 3'd5
`endif
    } state_t;

    localparam logic [7:0] MAX_T = 8'(MAX_TRIES);
    localparam logic [6:0] W_LIM = 7'(GRID_W);
    localparam logic [6:0] H_LIM = 7'(GRID_H);
`ifdef FOOD_FALLBACK_SCAN_EN
    localparam logic [6:0] X_LAST = 7'(GRID_W - 1);
    localparam logic [6:0] Y_LAST = 7'(GRID_H - 1);
    logic       scan_q, scan_d;
`endif

    state_t     state_q, state_d;
    logic [7:0] try_q, try_d;
    logic [6:0] cand_x_q, cand_x_d, cand_y_q, cand_y_d;
    logic [6:0] qry_x_q, qry_x_d, qry_y_q, qry_y_d;
    logic       qry_valid_q, qry_valid_d;
    logic [6:0] food_x_q, food_x_d, food_y_q, food_y_d;
    logic       food_valid_q, food_valid_d;
    logic       done_q, done_d, fail_q, fail_d;
    logic       exhaust;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            try_q        <= '0;
            cand_x_q     <= '0;
            cand_y_q     <= '0;
            qry_x_q      <= '0;
            qry_y_q      <= '0;
            qry_valid_q  <= 1'b0;
            food_x_q     <= '0;
            food_y_q     <= '0;
            food_valid_q <= 1'b0;
            done_q       <= 1'b0;
            fail_q       <= 1'b0;
`ifdef FOOD_FALLBACK_SCAN_EN
            scan_q       <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            try_q        <= try_d;
            cand_x_q     <= cand_x_d;
            cand_y_q     <= cand_y_d;
            qry_x_q      <= qry_x_d;
            qry_y_q      <= qry_y_d;
            qry_valid_q  <= qry_valid_d;
            food_x_q     <= food_x_d;
            food_y_q     <= food_y_d;
            food_valid_q <= food_valid_d;
            done_q       <= done_d;
            fail_q       <= fail_d;
`ifdef FOOD_FALLBACK_SCAN_EN
            scan_q       <= scan_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        try_d        = try_q;
        cand_x_d     = cand_x_q;
        cand_y_d     = cand_y_q;
        qry_x_d      = qry_x_q;
        qry_y_d      = qry_y_q;
        qry_valid_d  = 1'b0;
        food_x_d     = food_x_q;
        food_y_d     = food_y_q;
        food_valid_d = food_valid_q;
        done_d       = 1'b0;
        fail_d       = 1'b0;
        exhaust      = 1'b0;
`ifdef FOOD_FALLBACK_SCAN_EN
        scan_d       = scan_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (spawn_req) begin
                    state_d      = S_SAMPLE;
                    food_valid_d = 1'b0;
                    try_d        = '0;
`ifdef FOOD_FALLBACK_SCAN_EN
                    scan_d       = 1'b0;
`endif
                end
            end
            S_SAMPLE: begin
                cand_x_d = rand_x;
                cand_y_d = rand_y;
                try_d    = try_q + 8'd1;
                if (rand_x < W_LIM && rand_y < H_LIM) begin
                    state_d     = S_QUERY;
                    qry_valid_d = 1'b1;
                    qry_x_d     = rand_x;
                    qry_y_d     = rand_y;
                end else if (try_d >= MAX_T) begin
                    exhaust = 1'b1;
                end
            end
            S_QUERY: state_d = S_WAIT;
            S_WAIT: begin
                if (occ_valid) begin
                    if (!occ_hit) begin
                        state_d = S_PLACE;
                    end else
`ifdef FOOD_FALLBACK_SCAN_EN
                    if (scan_q) begin
                        state_d = S_SCAN;
                        if (cand_x_q == X_LAST) begin
                            cand_x_d = '0;
                            cand_y_d = cand_y_q + 7'd1;
                            if (cand_y_q == Y_LAST) begin
                                state_d = S_IDLE;
                                fail_d  = 1'b1;
                            end
                        end else begin
                            cand_x_d = cand_x_q + 7'd1;
                        end
                    end else
`endif
                    if (try_q >= MAX_T) begin
                        exhaust = 1'b1;
                    end else begin
                        state_d = S_SAMPLE;
                    end
                end
            end
            S_PLACE: begin
                food_x_d     = cand_x_q;
                food_y_d     = cand_y_q;
                food_valid_d = 1'b1;
                done_d       = 1'b1;
                state_d      = S_IDLE;
            end
`ifdef FOOD_FALLBACK_SCAN_EN
            S_SCAN: begin
                state_d     = S_QUERY;
                qry_valid_d = 1'b1;
                qry_x_d     = cand_x_q;
                qry_y_d     = cand_y_q;
            end
`endif
            default: state_d = S_IDLE;
        endcase
        // Random tries used up: either fall back to a raster scan or give up.
        if (exhaust) begin
`ifdef FOOD_FALLBACK_SCAN_EN
            state_d  = S_SCAN;
            cand_x_d = '0;
            cand_y_d = '0;
            scan_d   = 1'b1;
`else
            state_d  = S_IDLE;
            fail_d   = 1'b1;
`endif
        end
    end

    always_comb begin
        busy       = (state_q != S_IDLE);
        qry_valid  = qry_valid_q;
        qry_x      = qry_x_q;
        qry_y      = qry_y_q;
        food_x     = food_x_q;
        food_y     = food_y_q;
        food_valid = food_valid_q;
        spawn_done = done_q;
        spawn_fail = fail_q;
    end
endmodule

// File: tb/tb_food_spawner.sv
// Directed bench for food_spawner: table of single-spawn vectors plus
// hand-written exhaustion, busy-request and mid-spawn reset sequences.
module tb_food_spawner;
    logic       clk = 1'b0;
    logic       rst;
    logic       spawn_req;
    logic [6:0] rand_x, rand_y;
    logic       qry_valid;
    logic [6:0] qry_x, qry_y;
    logic       occ_valid, occ_hit;
    logic [6:0] food_x, food_y;
    logic       food_valid, busy, spawn_done, spawn_fail;

    food_spawner dut (
        .clk(clk), .rst(rst), .spawn_req(spawn_req),
        .rand_x(rand_x), .rand_y(rand_y),
        .qry_valid(qry_valid), .qry_x(qry_x), .qry_y(qry_y),
        .occ_valid(occ_valid), .occ_hit(occ_hit),
        .food_x(food_x), .food_y(food_y), .food_valid(food_valid),
        .busy(busy), .spawn_done(spawn_done), .spawn_fail(spawn_fail)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        int nbad, bx, by, x1, y1, hit1, x2, y2, efx, efy, enq, elat;
    } vec_t;

    vec_t vecs[6];
    vec_t cur;
    int   n_vec = 0;
    int   n_err = 0;
    int   t_mode;
    int   r_lat, r_nq, r_done, r_fail;
    int   r_qx[$], r_qy[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic get_hit(input int idx, input int qx, input int qy);
        if (t_mode == 0) return (idx == 0) ? cur.hit1[0] : 1'b0;
        return (idx < 16) ? 1'b1 : !(qx == 3 && qy == 0);
    endfunction

    task automatic set_rand(input int k);
        if (k <= cur.nbad) begin
            rand_x = 7'(cur.bx); rand_y = 7'(cur.by);
        end else if (r_nq == 0) begin
            rand_x = 7'(cur.x1); rand_y = 7'(cur.y1);
        end else begin
            rand_x = 7'(cur.x2); rand_y = 7'(cur.y2);
        end
    endtask

    // Issues one spawn_req, answers each query in the following cycle.
    task automatic run_spawn(input int budget);
        bit pend = 0;
        r_nq = 0; r_done = 0; r_fail = 0; r_lat = -1;
        r_qx.delete(); r_qy.delete();
        spawn_req = 1'b1;
        set_rand(0);
        for (int k = 1; k <= budget; k++) begin
            tick();
            spawn_req = 1'b0; occ_valid = 1'b0; occ_hit = 1'b0;
            if (pend) begin
                occ_valid = 1'b1;
                occ_hit   = get_hit(r_nq - 1, r_qx[r_nq-1], r_qy[r_nq-1]);
                pend = 0;
            end
            set_rand(k);
            if (k == 1) begin
                chk("busy_after_req", int'(busy), 1);
                chk("food_valid_cleared", int'(food_valid), 0);
            end
            if (qry_valid) begin
                r_qx.push_back(int'(qry_x)); r_qy.push_back(int'(qry_y));
                r_nq++;
                pend = 1;
            end else if (r_nq > 0 && (qry_x != 7'(r_qx[r_nq-1]) || qry_y != 7'(r_qy[r_nq-1]))) begin
                chk("qry_hold", int'({qry_x, qry_y}), (r_qx[r_nq-1] << 7) | r_qy[r_nq-1]);
            end
            if (spawn_done || spawn_fail) begin
                r_lat = k; r_done = int'(spawn_done); r_fail = int'(spawn_fail);
                break;
            end
        end
        if (r_lat < 0) chk("spawn_timeout", r_lat, budget);
        tick();
        occ_valid = 1'b0;
        chk("done_pulse_width", int'(spawn_done | spawn_fail), 0);
        chk("busy_after_spawn", int'(busy), 0);
    endtask

    initial begin
        int cnt;
        vecs[0] = '{0, 100, 10, 10, 20, 0, 0, 0, 10, 20, 1, 5};
        vecs[1] = '{2, 100, 10, 12, 34, 0, 0, 0, 12, 34, 1, 7};
        vecs[2] = '{0, 100, 10,  5,  5, 1, 7, 9,  7,  9, 2, 8};
        vecs[3] = '{0,   0,  0, 79, 59, 0, 0, 0, 79, 59, 1, 5};
        vecs[4] = '{1,  80,  0,  0,  0, 0, 0, 0,  0,  0, 1, 6};
        vecs[5] = '{3,   0, 60, 40, 30, 0, 0, 0, 40, 30, 1, 8};

        rst = 1'b0; spawn_req = 1'b0; occ_valid = 1'b0; occ_hit = 1'b0;
        rand_x = '0; rand_y = '0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        chk("rst_outputs", int'({qry_valid, qry_x, qry_y, food_x, food_y,
                                 food_valid, busy, spawn_done, spawn_fail}), 0);

        t_mode = 0;
        for (int i = 0; i < 6; i++) begin
            cur = vecs[i];
            run_spawn(60);
            chk($sformatf("v%0d_done", i), r_done, 1);
            chk($sformatf("v%0d_latency", i), r_lat, cur.elat);
            chk($sformatf("v%0d_nq", i), r_nq, cur.enq);
            chk($sformatf("v%0d_food_x", i), int'(food_x), cur.efx);
            chk($sformatf("v%0d_food_y", i), int'(food_y), cur.efy);
            chk($sformatf("v%0d_food_valid", i), int'(food_valid), 1);
            if (r_nq > 0) chk($sformatf("v%0d_last_qry", i),
                              (r_qx[r_nq-1] << 7) | r_qy[r_nq-1], (cur.efx << 7) | cur.efy);
        end

        // every random try answered occupied
        t_mode = 1;
        cur = '{0, 0, 0, 1, 1, 1, 1, 1, 0, 0, 0, 0};
        run_spawn(200);
`ifdef FOOD_FALLBACK_SCAN_EN
        chk("scan_done", r_done, 1);
        chk("scan_nq", r_nq, 20);
        chk("scan_latency", r_lat, 62);
        if (r_nq > 16) chk("scan_first_cell", (r_qx[16] << 7) | r_qy[16], 0);
        chk("scan_food_x", int'(food_x), 3);
        chk("scan_food_y", int'(food_y), 0);
        chk("scan_food_valid", int'(food_valid), 1);
`else
        chk("exhaust_fail", r_fail, 1);
        chk("exhaust_done", r_done, 0);
        chk("exhaust_nq", r_nq, 16);
        chk("exhaust_latency", r_lat, 49);
        chk("exhaust_food_valid", int'(food_valid), 0);
`endif

        // spawn_req during WAIT must not be queued
        t_mode = 0;
        rand_x = 7'd20; rand_y = 7'd21;
        spawn_req = 1'b1;
        tick(); spawn_req = 1'b0;
        tick(); chk("busyreq_qry", int'(qry_valid), 1);
        tick(); spawn_req = 1'b1;
        tick(); spawn_req = 1'b0;
        chk("busyreq_wait_busy", int'(busy), 1);
        occ_valid = 1'b1; occ_hit = 1'b0;
        tick(); occ_valid = 1'b0;
        tick();
        chk("busyreq_done", int'(spawn_done), 1);
        chk("busyreq_food", int'({food_x, food_y}), (20 << 7) | 21);
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (busy || qry_valid || spawn_done) cnt++;
        end
        chk("busyreq_not_queued", cnt, 0);

        // reset in WAIT, late occupancy response must be ignored
        rand_x = 7'd30; rand_y = 7'd31;
        spawn_req = 1'b1;
        tick(); spawn_req = 1'b0;
        tick();
        tick(); rst = 1'b0;
        tick(); rst = 1'b1;
        chk("midrst_outputs", int'({qry_valid, qry_x, qry_y, food_x, food_y,
                                    food_valid, busy, spawn_done, spawn_fail}), 0);
        occ_valid = 1'b1; occ_hit = 1'b0;
        tick(); occ_valid = 1'b0;
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            if (busy || qry_valid || spawn_done || spawn_fail || food_valid) cnt++;
            tick();
        end
        chk("midrst_no_activity", cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
